// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the FFT twiddle generator.
// Table values are computed in integer Q30 arithmetic so no real math reaches synthesis.
package fft_pkg;

    localparam int     TW_MAX_DW = 32;
    localparam longint PI_Q30    = 64'sd3373259426;

    typedef struct packed {
        logic signed [TW_MAX_DW-1:0] re;
        logic signed [TW_MAX_DW-1:0] im;
    } tw_t;

    function automatic int log2_ceil(input int v);
        return $clog2(v);
    endfunction

    // Q-format +1.0 for a given word width: two integer bits, DW-2 fraction bits.
    function automatic longint q_one(input int dw);
        return 64'sd1 <<< (dw - 2);
    endfunction

    function automatic longint rnd_q30(input longint v, input int dw);
        longint p;
        longint half;
        half = 64'sd1 <<< 29;
        p    = v * q_one(dw);
        if (p >= 0) return (p + half) >>> 30;
        return -((-p + half) >>> 30);
    endfunction

    // (round(q*cos), round(-q*sin)) for angle 2*pi*k/n, k in the first quadrant.
    function automatic tw_t tw_rom_val(input int k, input int n, input int dw);
        longint x, x2, c_sum, c_term, s_sum, s_term;
        tw_t    r;
        x      = (64'sd2 * PI_Q30 * longint'(k)) / longint'(n);
        x2     = (x * x) >>> 30;
        c_sum  = 64'sd1 <<< 30;
        c_term = c_sum;
        s_sum  = x;
        s_term = x;
        for (int i = 1; i <= 12; i++) begin
            c_term = -((c_term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            c_sum  = c_sum + c_term;
            s_term = -((s_term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
            s_sum  = s_sum + s_term;
        end
        r.re = TW_MAX_DW'(rnd_q30(c_sum, dw));
        r.im = TW_MAX_DW'(-rnd_q30(s_sum, dw));
        return r;
    endfunction

endpackage

// File: rtl/fft_tw_rom.sv
// Quarter-wave twiddle ROM plus second-quadrant fold; purely combinational.
// Output fields are sign-extended from DW bits into the shared tw_t container.
module fft_tw_rom
    import fft_pkg::*;
#(
    parameter  int N_FFT = 64,
    parameter  int DW    = 10,
    localparam int KW    = log2_ceil(N_FFT) - 1
) (
    input  logic [KW-1:0] k,
    output tw_t           tw
);

    localparam int QW = KW - 1;
    localparam int QN = N_FFT / 4;

    logic signed [DW-1:0] rom_a [QN];
    logic signed [DW-1:0] rom_b [QN];
    logic signed [DW-1:0] a, b, re, im;

    for (genvar i = 0; i < QN; i++) begin : g_rom
        localparam tw_t ENTRY = tw_rom_val(i, N_FFT, DW);
        assign rom_a[i] = ENTRY.re[DW-1:0];
        assign rom_b[i] = ENTRY.im[DW-1:0];
    end

    // Second quadrant: W^(k+N/4) = -j * W^k, i.e. (a, b) -> (b, -a).
    always_comb begin
        a = rom_a[k[QW-1:0]];
        b = rom_b[k[QW-1:0]];
        if (k[KW-1]) begin
            re = b;
            im = -a;
        end else begin
            re = a;
            im = b;
        end
        tw.re = TW_MAX_DW'(re);
        tw.im = TW_MAX_DW'(im);
    end

endmodule

// File: rtl/fft_tw_gen.sv
// Self-sequencing radix-2 DIF twiddle generator: walks every stage in butterfly order
// and presents one registered W_N^k per handshake, optionally conjugated.
module fft_tw_gen
    import fft_pkg::*;
#(
    parameter int N_FFT = 64,
    parameter int DW    = 10,
    parameter int LOG2N = log2_ceil(N_FFT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       inverse,
    output logic                       busy,
    output logic                       tw_valid,
    input  logic                       tw_ready,
    output logic signed [DW-1:0]       tw_re,
    output logic signed [DW-1:0]       tw_im,
    output logic [$clog2(LOG2N)-1:0]   tw_stage,
    output logic                       tw_last,
    output logic                       done
);

    localparam int SW = $clog2(LOG2N);
    localparam int JW = LOG2N - 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [JW-1:0]        j_q, j_d;
    logic                 inv_q, inv_d;
    logic                 tw_valid_q, tw_valid_d;
    logic                 tw_last_q, tw_last_d;
    logic signed [DW-1:0] tw_re_q, tw_re_d;
    logic signed [DW-1:0] tw_im_q, tw_im_d;
    logic [SW-1:0]        tw_stage_q, tw_stage_d;

    logic [JW-1:0]        mask, k;
    logic                 accept, adv, load, inv_eff, last_word;
    logic signed [DW-1:0] rom_re, rom_im;
    tw_t                  rom_tw;

    fft_tw_rom #(.N_FFT(N_FFT), .DW(DW)) u_rom (
        .k  (k),
        .tw (rom_tw)
    );

    // Counters rest at zero in IDLE, so the start cycle can load word 0 directly.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        busy      = (state_q == RUN) || tw_valid_q;
        mask      = {JW{1'b1}} >> s_q;
        k         = (j_q & mask) << s_q;
        accept    = (state_q == IDLE) && start && !busy;
        adv       = (state_q == RUN) && (!tw_valid_q || tw_ready);
        load      = accept || adv;
        inv_eff   = accept ? inverse : inv_q;
        last_word = (s_q == SW'(LOG2N - 1)) && (j_q == {JW{1'b1}});
        rom_re    = rom_tw.re[DW-1:0];
        rom_im    = rom_tw.im[DW-1:0];

        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        inv_d      = inv_q;
        tw_valid_d = tw_valid_q;
        tw_last_d  = tw_last_q;
        tw_re_d    = tw_re_q;
        tw_im_d    = tw_im_q;
        tw_stage_d = tw_stage_q;

        if (load) begin
            if (accept) inv_d = inverse;
            tw_re_d    = rom_re;
            tw_im_d    = inv_eff ? -rom_im : rom_im;
            tw_stage_d = s_q;
            tw_last_d  = last_word;
            tw_valid_d = 1'b1;
            if (last_word) begin
                state_d = IDLE;
                s_d     = '0;
                j_d     = '0;
            end else begin
                state_d = RUN;
                j_d     = j_q + JW'(1);
                if (j_q == {JW{1'b1}}) s_d = s_q + SW'(1);
            end
        end else if (tw_valid_q && tw_ready) begin
            tw_valid_d = 1'b0;
            tw_last_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            j_q        <= '0;
            inv_q      <= 1'b0;
            tw_valid_q <= 1'b0;
            tw_last_q  <= 1'b0;
            tw_re_q    <= '0;
            tw_im_q    <= '0;
            tw_stage_q <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            inv_q      <= inv_d;
            tw_valid_q <= tw_valid_d;
            tw_last_q  <= tw_last_d;
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
            tw_stage_q <= tw_stage_d;
        end
    end

    assign tw_valid = tw_valid_q;
    assign tw_last  = tw_last_q;
    assign tw_re    = tw_re_q;
    assign tw_im    = tw_im_q;
    assign tw_stage = tw_stage_q;
    assign done     = tw_valid_q && tw_ready && tw_last_q;

    // The fold must stay inside DW bits; the container's upper bits are pure sign extension.
    rom_fits_a: assert property (@(posedge clk) disable iff (rst)
        (rom_tw.re == TW_MAX_DW'(rom_re)) && (rom_tw.im == TW_MAX_DW'(rom_im)));

endmodule

// File: tb/tb_fft_tw_gen.sv
// Scoreboard bench for fft_tw_gen: an N=8 instance for directed sequences and an
// N=64 instance under random backpressure, both checked against a cos/sin model.
module tb_fft_tw_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start8, inv8, rdy8, busy8, v8, last8, done8;
    logic signed [9:0] re8, im8;
    logic [1:0]        stg8;

    logic              start64, inv64, rdy64, busy64, v64, last64, done64;
    logic signed [9:0] re64, im64;
    logic [2:0]        stg64;

    fft_tw_gen #(.N_FFT(8), .DW(10)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .inverse(inv8), .busy(busy8),
        .tw_valid(v8), .tw_ready(rdy8), .tw_re(re8), .tw_im(im8),
        .tw_stage(stg8), .tw_last(last8), .done(done8)
    );

    fft_tw_gen #(.N_FFT(64), .DW(10)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .inverse(inv64), .busy(busy64),
        .tw_valid(v64), .tw_ready(rdy64), .tw_re(re64), .tw_im(im64),
        .tw_stage(stg64), .tw_last(last64), .done(done64)
    );

    typedef struct {
        int  re;
        int  im;
        int  stage;
        int  last;
        real er;
        real ei;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    int   checks  = 0;
    int   errors  = 0;
    int   acc8    = 0;
    int   acc64   = 0;
    real  max_err = 0.0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    // Reference: W_N^k = e^(-j*2*pi*k/N) scaled by 256, butterfly order per stage.
    function automatic void push_seq(input int n, input bit inv);
        int   lg;
        int   span;
        int   k;
        real  ang;
        exp_t e;
        lg = $clog2(n);
        for (int s = 0; s < lg; s++) begin
            for (int j = 0; j < n / 2; j++) begin
                span    = n >> (s + 1);
                k       = (j % span) * (1 << s);
                ang     = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
                e.er    = 256.0 * $cos(ang);
                e.ei    = -256.0 * $sin(ang);
                if (inv) e.ei = -e.ei;
                e.re    = rnd(e.er);
                e.im    = rnd(e.ei);
                e.stage = s;
                e.last  = (s == lg - 1 && j == n / 2 - 1) ? 1 : 0;
                if (n == 8) q8.push_back(e);
                else q64.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst) begin
            if (v8 && rdy8) begin
                if (q8.size() == 0) begin
                    check("w8_unexpected", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("w8_re", int'(re8), e.re);
                    check("w8_im", int'(im8), e.im);
                    check("w8_stage", int'(stg8), e.stage);
                    check("w8_last", int'(last8), e.last);
                    check("w8_done", int'(done8), e.last);
                end
                acc8++;
            end else if (done8) begin
                check("w8_spurious_done", 1, 0);
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        real  d;
        if (!rst) begin
            if (v64 && rdy64) begin
                if (q64.size() == 0) begin
                    check("w64_unexpected", 1, 0);
                end else begin
                    e = q64.pop_front();
                    check("w64_re", int'(re64), e.re);
                    check("w64_im", int'(im64), e.im);
                    check("w64_stage", int'(stg64), e.stage);
                    check("w64_last", int'(last64), e.last);
                    check("w64_done", int'(done64), e.last);
                    d = real'(re64) - e.er;
                    if (d < 0.0) d = -d;
                    if (d > max_err) max_err = d;
                    d = real'(im64) - e.ei;
                    if (d < 0.0) d = -d;
                    if (d > max_err) max_err = d;
                end
                acc64++;
            end else if (done64) begin
                check("w64_spurious_done", 1, 0);
            end
        end
    end

    task automatic start8_pulse(input bit inv);
        acc8 = 0;
        push_seq(8, inv);
        inv8   = inv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("first_valid8", int'(v8), 1);
    endtask

    task automatic finish8(output int cyc);
        cyc = 0;
        while (!(v8 && rdy8 && last8) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) check("timeout8", 1, 0);
        tick();
        check("busy_after_done8", int'(busy8), 0);
        check("words8", acc8, 12);
    endtask

    task automatic wait_acc8(input int target);
        int n;
        n = 0;
        while (acc8 < target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("timeout_acc8", 1, 0);
    endtask

    task automatic run64(input bit inv);
        int n;
        bit hit;
        acc64 = 0;
        push_seq(64, inv);
        inv64   = inv;
        start64 = 1'b1;
        rdy64   = ($urandom_range(0, 3) != 0);
        tick();
        start64 = 1'b0;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 3000) begin
            rdy64 = ($urandom_range(0, 3) != 0);
            if (v64 && rdy64 && last64) hit = 1'b1;
            tick();
            n++;
        end
        if (!hit) check("timeout64", 1, 0);
        rdy64 = 1'b0;
        check("busy_after_done64", int'(busy64), 0);
        check("words64", acc64, 192);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        rst     = 1'b1;
        start8  = 1'b0;
        inv8    = 1'b0;
        rdy8    = 1'b1;
        start64 = 1'b0;
        inv64   = 1'b0;
        rdy64   = 1'b0;
        repeat (3) tick();
        check("rst_busy8", int'(busy8), 0);
        check("rst_valid8", int'(v8), 0);
        check("rst_last8", int'(last8), 0);
        check("rst_done8", int'(done8), 0);
        check("rst_re8", int'(re8), 0);
        check("rst_im8", int'(im8), 0);
        check("rst_stage8", int'(stg8), 0);
        check("rst_valid64", int'(v64), 0);
        rst = 1'b0;
        tick();

        // Full-throughput forward and inverse sequences.
        start8_pulse(1'b0);
        finish8(cyc);
        check("throughput8_fwd", cyc, 11);
        tick();
        start8_pulse(1'b1);
        finish8(cyc);
        check("throughput8_inv", cyc, 11);
        tick();

        // Stall three cycles on the second word.
        start8_pulse(1'b0);
        wait_acc8(1);
        rdy8 = 1'b0;
        repeat (3) begin
            tick();
            check("hold_valid8", int'(v8), 1);
            check("hold_re8", int'(re8), 181);
            check("hold_im8", int'(im8), -181);
            check("hold_stage8", int'(stg8), 0);
        end
        rdy8 = 1'b1;
        finish8(cyc);
        tick();

        // Starts while busy and in the done cycle are ignored.
        start8_pulse(1'b0);
        wait_acc8(4);
        inv8   = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("stage_after_busy_start8", int'(stg8), 1);
        cyc = 0;
        while (!(v8 && last8) && cyc < 100) begin
            tick();
            cyc++;
        end
        if (cyc >= 100) check("timeout_last8", 1, 0);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("no_restart_busy8", int'(busy8), 0);
        check("no_restart_valid8", int'(v8), 0);
        tick();
        check("no_restart_valid8_b", int'(v8), 0);
        check("words8_ignored_start", acc8, 12);

        // Reset in mid-sequence, then a fresh full run.
        start8_pulse(1'b0);
        wait_acc8(6);
        rst  = 1'b1;
        rdy8 = 1'b0;
        tick();
        check("abort_valid8", int'(v8), 0);
        check("abort_busy8", int'(busy8), 0);
        check("abort_done8", int'(done8), 0);
        rst = 1'b0;
        q8.delete();
        rdy8 = 1'b1;
        tick();
        check("abort_idle_valid8", int'(v8), 0);
        start8_pulse(1'b0);
        finish8(cyc);
        check("throughput8_after_rst", cyc, 11);

        // Large table under random backpressure.
        run64(1'b0);
        tick();
        run64(1'b1);
        tick();

        check("q8_drained", q8.size(), 0);
        check("q64_drained", q64.size(), 0);
        check("max_err_le_half_lsb", (max_err <= 0.5) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_tw_gen.md
Name: fft_tw_gen

Overview:
- Parametrised, self-sequencing twiddle-factor generator for the radix-2 DIF FFT datapath.
- On `start`, streams W_N^k = cos(2πk/N) − j·sin(2πk/N) in butterfly order for every stage, over a valid/ready handshake.
- Stores only the first quadrant (N/4 entries) and derives the second quadrant by symmetry.
- Optional inverse mode outputs conjugated factors.

Parameters:
- N_FFT, 64, FFT size; power of two, ≥ 8.
- DW, 10, width of each of re/im; signed two's complement, +1.0 = 2^(DW-2).
- LOG2N, $clog2(N_FFT), derived; number of stages.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a full sequence; ignored while busy=1
- inverse  in  1  sampled on an accepted start; 1 = output conjugate (im negated)
- busy  out  1  high from the accepted start until the last word is accepted
- tw_valid  out  1  output word valid
- tw_ready  in  1  consumer accepts the word when tw_valid && tw_ready
- tw_re  out  DW  real part
- tw_im  out  DW  imaginary part
- tw_stage  out  $clog2(LOG2N)  stage index of the current word
- tw_last  out  1  high on the final word of the final stage
- done  out  1  one-cycle pulse on the cycle the final word is accepted

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: busy, tw_valid, tw_last, done = 0; tw_re, tw_im, tw_stage = 0. Reset mid-sequence aborts it immediately, with no done pulse.
- FSM states: IDLE, RUN.
  - IDLE → RUN on start && !busy. Clears stage counter s and butterfly counter j, and latches inverse.
  - RUN → IDLE when the final (s = LOG2N−1, j = N/2−1) word is loaded into the output register.
  - busy = (state == RUN) || tw_valid.
- Counters: j counts 0..N/2−1 and then wraps to 0 while s increments.
- Exponent: k = (j mod (N/2^(s+1))) << s. The modulo is a mask; no divider.
- Quadrant fold (k in 0..N/2−1):
  - k < N/4: (re, im) = ROM[k] = (a, b), with a = round(2^(DW-2)·cos), b = round(−2^(DW-2)·sin).
  - k ≥ N/4: k' = k − N/4, (a, b) = ROM[k'], output (re, im) = (b, −a).
  - All negation is in DW bits. The 2-bit integer field guarantees no overflow.
- Inverse: im_out = −im after the fold.
- Pipeline:
  - Combinational ROM plus fold feed one output register. First tw_valid appears 1 cycle after the accepted start.
  - Advance condition: RUN && (!tw_valid || tw_ready). When true, the output register loads the next word and the counters step.
  - If in IDLE and tw_ready with tw_valid, tw_valid is cleared.
  - Full throughput: one word per cycle while tw_ready = 1.
- Backpressure: while tw_valid && !tw_ready, tw_re, tw_im, tw_stage and tw_last hold stable and the counters freeze.
- done: asserted in the cycle tw_valid && tw_ready && tw_last. busy falls the following cycle.
- start while busy is ignored. start in the same cycle as done is also ignored, because busy is still 1.
- The ROM is a constant function or case table generated per N_FFT/DW. Rounding is round-half-away-from-zero.

Decomposition:
- Package fft_pkg:
  - typedef tw_t: struct of signed [DW-1:0] re, im.
  - Constants for the Q-format one (2^(DW-2)).
  - Function tw_rom_val(k, N, DW) for table generation.
  - Helper clog2 wrappers.
- One sub-module: fft_tw_rom. It holds the combinational quarter-wave ROM plus the quadrant fold, with input k and output tw_t.
- fft_tw_gen holds the FSM, counters, handshake and output register.

Test Plan (N_FFT=8, DW=10):
- Reset, then start with inverse=0 and tw_ready=1. Required: 12 words, one per cycle, first word 1 cycle after start.
  - stage 0: (256,0), (181,−181), (0,−256), (−181,−181)
  - stage 1: (256,0), (0,−256), (256,0), (0,−256)
  - stage 2: 4× (256,0)
  - tw_last and done on word 12; busy low the cycle after.
- Same sequence with inverse=1. Required: im negated, e.g. stage 0 = (256,0), (181,181), (0,256), (−181,181).
- tw_ready low for 3 cycles while word 2 (181,−181) is presented. Required: outputs held, no word skipped or duplicated, total still 12.
- start pulsed at word 5 and again in the done cycle. Required: both ignored, no restart, tw_stage unchanged.
- rst asserted at word 7. Required: next cycle tw_valid=0, busy=0, no done pulse. A fresh start then yields a full correct 12-word sequence.
- N_FFT=64: check all 6·32 words against a reference model of round(256·e^(−j2πk/64)), with random tw_ready. Required: zero mismatches, max |error| ≤ 0.5 LSB.
